airi5c_wb_ahb_bridge: RTL and testbench

- Parametrised Wishbone-slave to AHB-Lite-master bridge between the management-SoC Wishbone port and an AIRISC-side AHB-Lite memory (IMEM/DMEM preload, debug access).
- Generalises the fixed-wait, always-OKAY memory hookup to:
  - a configurable address window;
  - a posted-write buffer of configurable depth;
  - byte/halfword/word sizing derived from byte selects;
  - a bus timeout with sticky error reporting.

---
 rtl/airi5c_wb_ahb_bridge_pkg.sv | 45 ++++
 rtl/airi5c_wb_ahb_bridge_wbuf.sv | 50 +++++
 rtl/airi5c_wb_ahb_bridge.sv | 164 ++++++++++++++++
 tb/tb_airi5c_wb_ahb_bridge.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_wb_ahb_bridge_pkg.sv
// Shared AHB-Lite encodings, FSM state type and Wishbone byte-select decode
// for the Wishbone-to-AHB bridge.
package airi5c_wb_ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  typedef struct packed {
    logic [2:0] size;
    logic [1:0] offset;
    logic       legal;
  } sel_dec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } wbuf_entry_t;

  function automatic sel_dec_t sel_decode(input logic [3:0] sel);
    sel_dec_t d;
    d = '{size: HSIZE_BYTE, offset: 2'b00, legal: 1'b1};
    case (sel)
      4'b1111: d.size = HSIZE_WORD;
      4'b0011: d.size = HSIZE_HALF;
      4'b1100: begin d.size = HSIZE_HALF; d.offset = 2'b10; end
      4'b0001: d.offset = 2'b00;
      4'b0010: d.offset = 2'b01;
      4'b0100: d.offset = 2'b10;
      4'b1000: d.offset = 2'b11;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/airi5c_wb_ahb_bridge_wbuf.sv
// Posted-write FIFO: synchronous, full/empty from registered occupancy so a
// push is refused while full even if a pop happens in the same cycle.
module airi5c_wb_ahb_wbuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/airi5c_wb_ahb_bridge.sv
// Wishbone slave to AHB-Lite master bridge with posted writes, read ordering
// behind buffered writes, byte-select sizing and a data-phase timeout.
//   state | meaning
//   IDLE  | pick next transfer: buffered write first, then pending read
//   ADDR  | NONSEQ address phase, held until hready
//   DATA  | data phase, ends on hready or timeout
module airi5c_wb_ahb_bridge
  import airi5c_wb_ahb_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'h0000_FFFF,
  parameter int          WBUF_DEPTH     = 2,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic        busy_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        ack_q, err_q, rd_pend_q, hwrite_q;
  logic [31:0] dat_q, rd_addr_q, haddr_q, hwdata_q;
  logic [2:0]  hsize_q;
  logic [1:0]  htrans_q;
  logic [TW-1:0] tmo_q;

  sel_dec_t    dec;
  wbuf_entry_t push_entry, head;
  logic [31:0] word_addr;
  logic        in_win, accept, wr_acc, rd_acc, bad_acc;
  logic        wbuf_full, wbuf_empty, wbuf_pop;
  logic        xfer_err, xfer_tmo, err_set;

  always_comb begin
    dec        = sel_decode(wbs_sel_i);
    in_win     = ((wbs_adr_i & ~ADDR_MASK) == BASE_ADDR);
    word_addr  = wbs_adr_i & ADDR_MASK & 32'hFFFF_FFFC;
    accept     = wbs_stb_i && wbs_cyc_i && in_win && !ack_q && !rd_pend_q;
    wr_acc     = accept && wbs_we_i && dec.legal && !wbuf_full;
    rd_acc     = accept && !wbs_we_i && dec.legal;
    bad_acc    = accept && !dec.legal;
    push_entry = '{addr: word_addr | {30'b0, dec.offset}, size: dec.size, data: wbs_dat_i};
    wbuf_pop   = (state_q == ST_IDLE) && !wbuf_empty;
    xfer_err   = (state_q == ST_DATA) && hready && (hresp == HRESP_ERROR);
    xfer_tmo   = (state_q == ST_DATA) && !hready && (tmo_q == '0);
    err_set    = bad_acc || xfer_err || xfer_tmo;
  end

  airi5c_wb_ahb_wbuf #(
    .WIDTH($bits(wbuf_entry_t)),
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk    (clk),
    .nreset (nreset),
    .push_i (wr_acc),
    .wdata_i(push_entry),
    .pop_i  (wbuf_pop),
    .rdata_o(head),
    .full_o (wbuf_full),
    .empty_o(wbuf_empty)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      dat_q     <= '0;
      rd_addr_q <= '0;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= '0;
      hwdata_q  <= '0;
      htrans_q  <= HTRANS_IDLE;
      tmo_q     <= '0;
    end else begin
      ack_q <= wr_acc || bad_acc;
      err_q <= err_set || (err_q && !err_clr_i);
      if (bad_acc && !wbs_we_i) dat_q <= ERR_DATA;
      if (rd_acc) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= word_addr;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (!wbuf_empty) begin
            haddr_q  <= head.addr;
            hwrite_q <= 1'b1;
            hsize_q  <= head.size;
            hwdata_q <= head.data;
            htrans_q <= HTRANS_NONSEQ;
            state_q  <= ST_ADDR;
          end else if (rd_pend_q || rd_acc) begin
            // Same-cycle issue keeps zero-wait read latency at three cycles.
            haddr_q  <= rd_pend_q ? rd_addr_q : word_addr;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            htrans_q <= HTRANS_NONSEQ;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (hready) begin
            htrans_q <= HTRANS_IDLE;
            tmo_q    <= TMO_LOAD;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (hready || xfer_tmo) begin
            state_q <= ST_IDLE;
            if (!hwrite_q) begin
              ack_q     <= 1'b1;
              rd_pend_q <= 1'b0;
              dat_q     <= (xfer_err || xfer_tmo) ? ERR_DATA : hrdata;
            end
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hwdata    = hwdata_q;
  assign htrans    = htrans_q;
  assign hburst    = HBURST_SINGLE;
  assign hmastlock = 1'b0;
  assign hprot     = HPROT_DEFAULT;
  assign err_o     = err_q;
  assign busy_o    = !wbuf_empty || (state_q != ST_IDLE) || rd_pend_q;

endmodule

// File: tb/tb_airi5c_wb_ahb_bridge.sv
// Self-checking bench: AHB slave model with a scoreboard of expected transfers
// plus per-scenario Wishbone tasks checking ack timing, read data and flags.
module tb_airi5c_wb_ahb_bridge;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        wbs_stb_i = 0, wbs_cyc_i = 0, wbs_we_i = 0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o, haddr, hwdata;
  logic        hwrite, hmastlock, err_o, busy_o;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hrdata = '0;
  logic        hready, hresp;
  logic        err_clr_i = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  xfer_t       ahb_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_xfer = 0;

  bit    hold_low = 0, sl_err = 0, sl_dp = 0;
  int    sl_wait = 0, sl_left = 0;
  xfer_t sl_cur;

  assign hready = !hold_low && (!sl_dp || sl_left == 0);
  assign hresp  = sl_dp && sl_err;

  always #5 clk = ~clk;

  airi5c_wb_ahb_bridge dut (
    .clk(clk), .nreset(nreset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .err_o(err_o), .err_clr_i(err_clr_i), .busy_o(busy_o)
  );

  // AHB slave: sample just before each rising edge, update just after it.
  logic        s_rst, s_take, s_done, s_w;
  logic [31:0] s_a, s_wd;
  logic [2:0]  s_sz;
  xfer_t       s_exp;
  initial forever begin
    @(negedge clk); #4;
    s_rst  = !nreset;
    s_take = nreset && htrans == 2'b10 && hready;
    s_done = sl_dp && hready;
    s_a = haddr; s_w = hwrite; s_sz = hsize; s_wd = hwdata;
    @(posedge clk); #1;
    if (s_rst || !nreset) begin
      sl_dp = 0; sl_left = 0;
    end else begin
      if (s_done) begin
        sl_dp = 0; n_xfer++;
        if (sl_cur.wr) begin
          n_checks++;
          if (s_wd !== sl_cur.data) begin
            n_fail++;
            $display("FAIL hwdata: got %h expected %h", s_wd, sl_cur.data);
          end
        end
      end
      if (s_take) begin
        n_checks++;
        if (ahb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_xfer: got haddr %h hwrite %b, expected none", s_a, s_w);
          sl_cur = '{addr: s_a, wr: 1'b0, size: s_sz, data: 32'h0};
        end else begin
          s_exp = ahb_q.pop_front();
          sl_cur = s_exp;
          if ({s_a, s_w, s_sz} !== {s_exp.addr, s_exp.wr, s_exp.size}) begin
            n_fail++;
            $display("FAIL addr_phase: got haddr %h hwrite %b hsize %b, expected %h %b %b",
                     s_a, s_w, s_sz, s_exp.addr, s_exp.wr, s_exp.size);
          end
        end
        sl_dp = 1; sl_left = sl_wait;
      end else if (sl_dp && sl_left > 0) begin
        sl_left--;
      end
    end
  end

  task automatic push_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                           input logic [31:0] d);
    ahb_q.push_back('{addr: a, wr: w, size: sz, data: d});
  endtask

  task automatic wb_start(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                          input logic [31:0] dat);
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_we_i = we; wbs_dat_i = dat;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
  endtask

  task automatic wait_ack(input int max_cyc, output int cyc, output bit got);
    got = 0; cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge clk); cyc++;
      if (wbs_ack_o) got = 1;
    end
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask

  task automatic drain(output bit ok);
    int i = 0;
    ok = 0;
    while (!ok && i < 1000) begin
      @(negedge clk); i++;
      if (!busy_o && !sl_dp && htrans == 2'b00) ok = 1;
    end
  endtask

  task automatic test_reset();
    nreset = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wbs_ack_o, wbs_dat_o} !== 33'h0) begin
      n_fail++; $display("FAIL reset_wb: got ack %b dat %h, expected 0 0", wbs_ack_o, wbs_dat_o);
    end
    n_checks++;
    if ({htrans, haddr, hwrite, hsize, hwdata} !== '0) begin
      n_fail++; $display("FAIL reset_ahb: got htrans %b haddr %h hwrite %b hsize %b hwdata %h, expected 0",
                         htrans, haddr, hwrite, hsize, hwdata);
    end
    n_checks++;
    if ({err_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_status: got err %b busy %b, expected 0 0", err_o, busy_o);
    end
    n_checks++;
    if ({hburst, hmastlock, hprot} !== {3'b000, 1'b0, 4'b0011}) begin
      n_fail++; $display("FAIL const_outputs: got hburst %b hmastlock %b hprot %b, expected 000 0 0011",
                         hburst, hmastlock, hprot);
    end
    nreset = 1;
    @(negedge clk);
  endtask

  task automatic test_word_write();
    int cyc; bit got, ok;
    push_xfer(32'h10, 1'b1, 3'b010, 32'hCAFE_F00D);
    wb_start(32'h3000_0010, 4'hF, 1'b1, 32'hCAFE_F00D);
    wait_ack(10, cyc, got);
    n_checks++;
    if (!got || cyc != 1) begin
      n_fail++; $display("FAIL word_write_ack: got ack=%b after %0d cycles, expected after 1", got, cyc);
    end
    drain(ok);
    n_checks++;
    if (!ok || err_o !== 1'b0) begin
      n_fail++; $display("FAIL word_write_drain: got idle=%b err %b, expected idle=1 err 0", ok, err_o);
    end
  endtask

  task automatic test_back_to_back_fifo();
    int cyc; bit got, ok, stalled;
    logic [31:0] rd;
    hold_low = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_xfer(32'h100 + 32'(i * 4), 1'b1, 3'b010, 32'hA000_0000 + 32'(i));
      wb_start(32'h3000_0100 + 32'(i * 4), 4'hF, 1'b1, 32'hA000_0000 + 32'(i));
      wait_ack(10, cyc, got);
      n_checks++;
      if (!got || cyc != 1) begin
        n_fail++; $display("FAIL posted_write_%0d: got ack=%b after %0d cycles, expected after 1", i, got, cyc);
      end
    end
    @(negedge clk);
    push_xfer(32'h10C, 1'b1, 3'b010, 32'hA000_0003);
    wb_start(32'h3000_010C, 4'hF, 1'b1, 32'hA000_0003);
    stalled = 1;
    repeat (10) begin
      @(negedge clk);
      if (wbs_ack_o) stalled = 0;
    end
    n_checks++;
    if (!stalled || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL full_stall: got stalled=%b busy %b, expected 1 1", stalled, busy_o);
    end
    hold_low = 0;
    wait_ack(20, cyc, got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL full_release: got no ack within %0d cycles, expected ack", cyc);
    end
    @(negedge clk);
    hrdata = 32'hA5A5_0001;
    push_xfer(32'h200, 1'b0, 3'b010, 32'h0);
    rd_q.push_back(32'hA5A5_0001);
    wb_start(32'h3000_0200, 4'hF, 1'b0, 32'h0);
    wait_ack(50, cyc, got);
    rd = rd_q.pop_front();
    n_checks++;
    if (!got || wbs_dat_o !== rd) begin
      n_fail++; $display("FAIL ordered_read: got ack=%b dat %h, expected ack=1 dat %h", got, wbs_dat_o, rd);
    end
    drain(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL fifo_drain: got busy, expected idle");
    end
  endtask

  task automatic test_sizes();
    logic [31:0] adrs [5] = '{32'h3000_0020, 32'h3000_0040, 32'h3000_0046, 32'h3000_0050, 32'h3000_0060};
    logic [3:0]  sels [5] = '{4'b0100, 4'b1100, 4'b0011, 4'b1000, 4'b0010};
    logic [31:0] exps [5] = '{32'h22, 32'h42, 32'h44, 32'h53, 32'h61};
    logic [2:0]  szs  [5] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
    int cyc, nx; bit got, ok, acked;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      push_xfer(exps[i], 1'b1, szs[i], 32'h00AB_0000 + 32'(i));
      wb_start(adrs[i], sels[i], 1'b1, 32'h00AB_0000 + 32'(i));
      wait_ack(10, cyc, got);
      n_checks++;
      if (!got || cyc != 1) begin
        n_fail++; $display("FAIL size_write_%0d: got ack=%b after %0d cycles, expected after 1", i, got, cyc);
      end
    end
    drain(ok);
    nx = n_xfer;
    @(negedge clk);
    wb_start(32'h3000_0030, 4'b0101, 1'b1, 32'h1111_2222);
    wait_ack(10, cyc, got);
    n_checks++;
    if (!got || cyc != 1 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL illegal_write: got ack=%b cyc %0d err %b, expected ack after 1, err 1", got, cyc, err_o);
    end
    @(negedge clk);
    wb_start(32'h3000_0034, 4'b0000, 1'b0, 32'h0);
    wait_ack(10, cyc, got);
    n_checks++;
    if (!got || cyc != 1 || wbs_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL illegal_read: got ack=%b cyc %0d dat %h, expected ack after 1 dat deadbeef", got, cyc, wbs_dat_o);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_xfer != nx || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL illegal_no_xfer: got %0d transfers busy %b, expected %0d busy 0", n_xfer, busy_o, nx);
    end
    err_clr_i = 1; @(negedge clk); err_clr_i = 0;
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got err %b, expected 0", err_o);
    end
    wb_start(32'h3001_0000, 4'hF, 1'b1, 32'h5555_5555);
    acked = 0;
    repeat (6) begin
      @(negedge clk);
      if (wbs_ack_o) acked = 1;
    end
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    n_checks++;
    if (acked || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL out_of_window: got ack=%b busy %b, expected 0 0", acked, busy_o);
    end
    err_clr_i = 1;
    wb_start(32'h3000_0038, 4'b0110, 1'b1, 32'h0);
    wait_ack(10, cyc, got);
    n_checks++;
    if (!got || err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_set_wins: got ack=%b err %b, expected 1 1", got, err_o);
    end
    @(negedge clk); err_clr_i = 0;
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_clear_after: got err %b, expected 0", err_o);
    end
  endtask

  task automatic test_read(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] ahb_a,
                           input logic [31:0] rdv, input int wait_cyc, input bit slave_err,
                           input int exp_cyc, input logic [31:0] exp_dat, input logic exp_err);
    int cyc; bit got;
    logic [31:0] rd;
    @(negedge clk);
    hrdata = rdv; sl_wait = wait_cyc; sl_err = slave_err;
    push_xfer(ahb_a, 1'b0, 3'b010, 32'h0);
    rd_q.push_back(exp_dat);
    wb_start(adr, sel, 1'b0, 32'h0);
    wait_ack(400, cyc, got);
    rd = rd_q.pop_front();
    n_checks++;
    if (!got || cyc != exp_cyc) begin
      n_fail++; $display("FAIL read_latency %h: got ack=%b after %0d cycles, expected after %0d", adr, got, cyc, exp_cyc);
    end
    n_checks++;
    if (wbs_dat_o !== rd || err_o !== exp_err) begin
      n_fail++; $display("FAIL read_data %h: got dat %h err %b, expected %h %b", adr, wbs_dat_o, err_o, rd, exp_err);
    end
    sl_wait = 0; sl_err = 0;
    repeat (3) @(negedge clk);
    err_clr_i = 1; @(negedge clk); err_clr_i = 0;
  endtask

  task automatic test_reset_mid();
    int cyc; bit got, acked;
    hold_low = 1;
    @(negedge clk);
    wb_start(32'h3000_0008, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (htrans !== 2'b10) begin
      n_fail++; $display("FAIL mid_addr_phase: got htrans %b, expected 10", htrans);
    end
    #2 nreset = 0;
    wbs_stb_i = 0; wbs_cyc_i = 0;
    #1;
    n_checks++;
    if ({htrans, busy_o, wbs_ack_o, haddr} !== 36'h0) begin
      n_fail++; $display("FAIL mid_reset: got htrans %b busy %b ack %b haddr %h, expected 0",
                         htrans, busy_o, wbs_ack_o, haddr);
    end
    @(negedge clk); nreset = 1; hold_low = 0;
    acked = 0;
    repeat (4) begin
      @(negedge clk);
      if (wbs_ack_o) acked = 1;
    end
    n_checks++;
    if (acked) begin
      n_fail++; $display("FAIL mid_reset_ack: got ack after reset, expected none");
    end
    test_read(32'h3000_0008, 4'hF, 32'h8, 32'h600D_CAFE, 0, 0, 3, 32'h600D_CAFE, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_write();
    test_back_to_back_fifo();
    test_sizes();
    test_read(32'h3000_0004, 4'hF,    32'h4, 32'h1234_5678, 0,   0, 3,   32'h1234_5678, 1'b0);
    test_read(32'h3000_0007, 4'b0010, 32'h4, 32'h0BAD_F00D, 0,   0, 3,   32'h0BAD_F00D, 1'b0);
    test_read(32'h3000_000C, 4'hF,    32'hC, 32'h7777_0000, 0,   1, 3,   32'hDEAD_BEEF, 1'b1);
    test_read(32'h3000_0010, 4'hF,    32'h10, 32'h2468_ACE0, 254, 0, 257, 32'h2468_ACE0, 1'b0);
    test_read(32'h3000_0014, 4'hF,    32'h14, 32'h1357_9BDF, 255, 0, 257, 32'hDEAD_BEEF, 1'b1);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_after_clear: got err %b, expected 0", err_o);
    end
    test_reset_mid();
    n_checks++;
    if (ahb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d outstanding transfers, expected 0", ahb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
